// File: rtl/pipe_scroller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_scroller_if: bird/game-logic <-> obstacle generator bundle  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface pipe_scroller_if;
    logic              start;
    logic [3:0]        bird_row;
    logic [15:0][15:0] green_array;
    logic [15:0]       green_column;
    logic              gameover;
    logic              running;

    modport master (
        output start, bird_row,
        input  green_array, green_column, gameover, running
    );

    modport slave (
        input  start, bird_row,
        output green_array, green_column, gameover, running
    );
endinterface
`default_nettype wire

// File: rtl/pipe_scroller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_scroller: scrolling pipe obstacles with collision detection |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module pipe_scroller #(
    parameter int SHIFT_PERIOD = 12_500_000,
    parameter int PIPE_SPACING = 6,
    parameter int GAP_HEIGHT   = 4,
    parameter int BIRD_COL     = 3
) (
    input  logic           clk,
    input  logic           rst,
    pipe_scroller_if.slave bus
);
    localparam int TICK_W = $clog2(SHIFT_PERIOD);
    localparam int SPC_W  = $clog2(PIPE_SPACING);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SHIFT_PERIOD - 1);
    localparam logic [SPC_W-1:0]  SPC_LOAD  = SPC_W'(PIPE_SPACING - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t            state_q;
    logic [15:0][15:0] array_q;
    logic [15:0][15:0] array_d;
    logic [TICK_W-1:0] tick_q;
    logic [SPC_W-1:0]  spc_q;
    logic [7:0]        lfsr_q;
    logic [7:0]        lfsr_d;
    logic              gameover_q;
    logic [15:0]       col_new_d;
    logic [3:0]        gap_top;
    logic              step;
    logic              hit;

    assign step   = (state_q == RUN) && (tick_q == TICK_LAST);
    assign hit    = (state_q == RUN) && array_q[bus.bird_row][BIRD_COL];
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Column entering at the right edge: a pipe with a gap, or empty between pipes.
    always_comb begin
        gap_top   = 4'd2 + {1'b0, lfsr_q[2:0]};
        col_new_d = '0;
        if (spc_q == '0) begin
            for (int r = 0; r < 16; r++) begin
                col_new_d[r] = !((r >= int'(gap_top)) && (r < int'(gap_top) + GAP_HEIGHT));
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 16; r++) begin
            array_d[r] = {col_new_d[r], array_q[r][15:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            array_q    <= '0;
            tick_q     <= '0;
            spc_q      <= '0;
            lfsr_q     <= 8'hA5;
            gameover_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    array_q <= '0;
                    tick_q  <= '0;
                    spc_q   <= '0;
                    if (bus.start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // A collision wins over a coincident step so the frozen image is the one that was hit.
                    if (hit) begin
                        gameover_q <= 1'b1;
                        state_q    <= OVER;
                    end else begin
                        tick_q <= step ? '0 : tick_q + 1'b1;
                        if (step) begin
                            array_q <= array_d;
                            if (spc_q == '0) begin
                                lfsr_q <= lfsr_d;
                                spc_q  <= SPC_LOAD;
                            end else begin
                                spc_q <= spc_q - 1'b1;
                            end
                        end
                    end
                end
                OVER: begin
                    state_q <= OVER;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.green_column = '0;
        for (int r = 0; r < 16; r++) begin
            bus.green_column[r] = array_q[r][BIRD_COL];
        end
    end

    assign bus.green_array = array_q;
    assign bus.gameover    = gameover_q;
    assign bus.running     = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_pipe_scroller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_scroller: directed self-checking bench, SHIFT_PERIOD = 4 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_pipe_scroller;
    localparam int SP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_scroller_if bus();

    pipe_scroller #(.SHIFT_PERIOD(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int nz_cycles;
    logic [15:0][15:0] exp_arr;
    // Gap tops hand-derived from LFSR states A5, 4A, 95, 2A, 54, A9, 53.
    logic [3:0] gap_tbl [0:6] = '{4'd7, 4'd4, 4'd7, 4'd4, 4'd6, 4'd3, 4'd5};

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pipe_col(input logic [3:0] g);
        logic [15:0] v;
        v = 16'hFFFF;
        for (int r = 0; r < 16; r++) begin
            if (r >= int'(g) && r < int'(g) + 4) v[r] = 1'b0;
        end
        return v;
    endfunction

    function automatic logic [15:0] col_of(input logic [15:0][15:0] a, input int c);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = a[r][c];
        return v;
    endfunction

    task automatic exp_shift(input int s);
        logic [15:0] nc;
        nc = ((s - 1) % 6 == 0) ? pipe_col(gap_tbl[(s - 1) / 6]) : 16'h0000;
        for (int r = 0; r < 16; r++) exp_arr[r] = {nc[r], exp_arr[r][15:1]};
    endtask

    task automatic build_exp(input int n);
        exp_arr = '0;
        for (int s = 1; s <= n; s++) exp_shift(s);
    endtask

    task automatic start_game();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("running_after_start", bus.running, 1);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.bird_row = 4'd0;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_array", bus.green_array, 0);
        check_eq("rst_gameover", bus.gameover, 0);
        check_eq("rst_running", bus.running, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_array", bus.green_array, 0);
        check_eq("idle_running", bus.running, 0);

        // First pipes, gap pass-through and long run.
        bus.bird_row = 4'd8;
        start_game();
        exp_arr = '0;
        check_eq("pre_step_array", bus.green_array, 0);
        nz_cycles = 0;
        for (int s = 1; s <= 40; s++) begin
            for (int k = 0; k < SP; k++) begin
                @(posedge clk);
                if (k == SP - 1) exp_shift(s);
                @(negedge clk);
                check_eq("green_column", bus.green_column, col_of(exp_arr, 3));
                check_eq("no_gameover", bus.gameover, 0);
                if (s <= 15 && bus.green_column != 16'h0000) nz_cycles++;
            end
            check_eq("array", bus.green_array, exp_arr);
            if (s == 1)  check_eq("pipe1_col15", col_of(bus.green_array, 15), 16'hF87F);
            if (s == 7)  check_eq("pipe2_col15", col_of(bus.green_array, 15), 16'hFF0F);
            if (s == 13) check_eq("pipe1_at_bird", bus.green_column, 16'hF87F);
            if (s == 14) check_eq("pipe1_left_bird", bus.green_column, 16'h0000);
            if (s >= 16 && (s - 16) % 6 == 0) bus.bird_row = gap_tbl[(s - 16) / 6 + 1] + 4'd1;
        end
        check_eq("gap_window_cycles", nz_cycles, 4);
        check_eq("running_long", bus.running, 1);

        // Asynchronous reset mid-run.
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_array", bus.green_array, 0);
        check_eq("async_rst_gameover", bus.gameover, 0);
        check_eq("async_rst_running", bus.running, 0);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("post_rst_array", bus.green_array, 0);
        check_eq("post_rst_running", bus.running, 0);

        // Collision with the first pipe at the bird column.
        bus.bird_row = 4'd0;
        start_game();
        build_exp(13);
        repeat (13 * SP) @(posedge clk);
        @(negedge clk);
        check_eq("hit_cycle_column", bus.green_column, 16'hF87F);
        check_eq("hit_cycle_gameover", bus.gameover, 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("hit_gameover", bus.gameover, 1);
        check_eq("hit_running", bus.running, 0);
        bus.start = 1'b1;
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("over_frozen_array", bus.green_array, exp_arr);
        check_eq("over_gameover_held", bus.gameover, 1);
        check_eq("over_ignores_start", bus.running, 0);
        #2 rst = 1'b0;
        #1;
        check_eq("over_rst_gameover", bus.gameover, 0);
        check_eq("over_rst_array", bus.green_array, 0);
        #2 rst = 1'b1;

        // Collision arriving in the same cycle as a step.
        bus.bird_row = 4'd8;
        start_game();
        build_exp(13);
        repeat (14 * SP - 1) @(posedge clk);
        @(negedge clk);
        bus.bird_row = 4'd0;
        check_eq("coinc_pre_column", bus.green_column, 16'hF87F);
        @(posedge clk);
        @(negedge clk);
        check_eq("coinc_gameover", bus.gameover, 1);
        check_eq("coinc_array_frozen", bus.green_array, exp_arr);
        check_eq("coinc_column", bus.green_column, 16'hF87F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
